// File: rtl/mem_req_pkg.sv
// Shared types and widths for the memory request unit.
package mem_req_pkg;

   localparam int unsigned ADR_W   = 16;
   localparam int unsigned DAT_W   = 16;
   localparam int unsigned MUTEX_W = 10;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'd0,
      OP_STORE  = 2'd1,
      OP_LOCK   = 2'd2,
      OP_UNLOCK = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MEM     = 3'd1,
      ST_LOCK    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_UNLOCK  = 3'd4,
      ST_RESP    = 3'd5
   } state_e;

   // Bits needed to hold a counter value in 0..max_val.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/lock_backoff.sv
// Exponential backoff timer: interval starts at 1, doubles per failure, saturates at BACKOFF_MAX.
module lock_backoff
   import mem_req_pkg::*;
#(
   parameter int unsigned BACKOFF_MAX = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic fail,
   input  logic tick,
   output logic expired
);

   localparam int unsigned BW = cnt_w(BACKOFF_MAX);

   logic [BW-1:0] intv_q, intv_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [BW:0]   dbl;

   // Reload, doubling and countdown of the current wait interval.
   always_comb begin
      intv_d = intv_q;
      cnt_d  = cnt_q;
      dbl    = {intv_q, 1'b0};
      if (clear) begin
         intv_d = BW'(1);
         cnt_d  = '0;
      end else if (fail) begin
         cnt_d  = intv_q;
         intv_d = (dbl > (BW + 1)'(BACKOFF_MAX)) ? BW'(BACKOFF_MAX) : dbl[BW-1:0];
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - BW'(1);
      end
   end

   // Last waiting cycle of the interval.
   assign expired = tick && (cnt_q == BW'(1));

   // Interval and countdown registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         intv_q <= BW'(1);
         cnt_q  <= '0;
      end else begin
         intv_q <= intv_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_req_unit.sv
// Core-side request unit: shared-memory LOAD/STORE and mutex LOCK/UNLOCK with backoff.
module mem_req_unit
   import mem_req_pkg::*;
#(
   parameter int unsigned LOCK_TRIES  = 16,
   parameter int unsigned BACKOFF_MAX = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [ADR_W-1:0]   req_adr,
   input  logic [DAT_W-1:0]   req_dat,
   output logic               rsp_valid,
   output logic [DAT_W-1:0]   rsp_dat,
   output logic               rsp_err,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADR_W-1:0]   mem_read_adr,
   output logic [ADR_W-1:0]   mem_write_adr,
   output logic [DAT_W-1:0]   mem_write_dat,
   output logic [MUTEX_W-1:0] lock_adr,
   output logic               lock_en,
   output logic               unlock_en,
   input  logic [DAT_W-1:0]   mem_dat,
   input  logic               mem_ac,
   input  logic               lock_ac
);

   localparam int unsigned TW = cnt_w(LOCK_TRIES);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [DAT_W-1:0] dat_q, dat_d;
   logic [TW-1:0]    tries_q, tries_d, tries_inc;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
   logic             rsp_err_q, rsp_err_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic             lock_en_q, lock_en_d;
   logic             unlock_en_q, unlock_en_d;
   logic             bo_clear, bo_fail, bo_tick, bo_expired;

   lock_backoff #(.BACKOFF_MAX(BACKOFF_MAX)) u_backoff (
      .clk     (clk),
      .reset   (reset),
      .clear   (bo_clear),
      .fail    (bo_fail),
      .tick    (bo_tick),
      .expired (bo_expired)
   );

   // Next state, request latching, and registered outputs decoded from the next state.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      tries_d   = tries_q;
      tries_inc = tries_q + TW'(1);
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      bo_clear  = 1'b0;
      bo_fail   = 1'b0;
      bo_tick   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               op_d      = op_e'(req_op);
               adr_d     = req_adr;
               dat_d     = req_dat;
               tries_d   = '0;
               rsp_dat_d = '0;
               rsp_err_d = 1'b0;
               bo_clear  = 1'b1;
               case (op_e'(req_op))
                  OP_LOCK:   state_d = ST_LOCK;
                  OP_UNLOCK: state_d = ST_UNLOCK;
                  default:   state_d = ST_MEM;
               endcase
            end
         end
         ST_MEM: begin
            if (mem_ac) begin
               state_d = ST_RESP;
               if (op_q == OP_LOAD) rsp_dat_d = mem_dat;
            end
         end
         ST_LOCK: begin
            if (lock_ac) begin
               state_d = ST_RESP;
            end else begin
               tries_d = tries_inc;
               if (tries_inc == TW'(LOCK_TRIES)) begin
                  state_d   = ST_RESP;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d = ST_BACKOFF;
                  bo_fail = 1'b1;
               end
            end
         end
         ST_BACKOFF: begin
            bo_tick = 1'b1;
            if (bo_expired) state_d = ST_LOCK;
         end
         ST_UNLOCK: begin
            if (lock_ac) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      mem_read_d  = (state_d == ST_MEM) && (op_d == OP_LOAD);
      mem_write_d = (state_d == ST_MEM) && (op_d == OP_STORE);
      lock_en_d   = (state_d == ST_LOCK);
      unlock_en_d = (state_d == ST_UNLOCK);
   end

   // State, latches and output registers; reset also cancels any in-flight request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LOAD;
         adr_q       <= '0;
         dat_q       <= '0;
         tries_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         lock_en_q   <= 1'b0;
         unlock_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         tries_q     <= tries_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         lock_en_q   <= lock_en_d;
         unlock_en_q <= unlock_en_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_dat       = rsp_dat_q;
   assign rsp_err       = rsp_err_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_read_adr  = adr_q;
   assign mem_write_adr = adr_q;
   assign mem_write_dat = dat_q;
   assign lock_adr      = adr_q[MUTEX_W-1:0];
   assign lock_en       = lock_en_q;
   assign unlock_en     = unlock_en_q;

endmodule

// File: tb/tb_mem_req_unit.sv
// Bench for mem_req_unit: two instances (different lock parameters) share all inputs but req_valid.
module tb_mem_req_unit;

   localparam int A_TRIES = 4;
   localparam int A_BMAX  = 8;
   localparam int B_TRIES = 7;
   localparam int B_BMAX  = 4;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_op;
   logic [15:0] req_adr, req_dat, mem_dat;
   logic        mem_ac, lock_ac;

   logic [1:0]  rdy_o, rv_o, err_o, mr_o, mw_o, le_o, ue_o;
   logic [15:0] rdat_o [2];
   logic [15:0] mra_o  [2];
   logic [15:0] mwa_o  [2];
   logic [15:0] mwd_o  [2];
   logic [9:0]  ladr_o [2];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [63:0] mr;
      logic [63:0] mw;
      logic [63:0] le;
      logic [63:0] ue;
      logic [63:0] rdy;
      logic [6:0]  rsp_at;
      logic [15:0] dat;
      logic        err;
      logic [7:0]  adr_bad;
      logic [7:0]  wt;
   } trace_t;

   mem_req_unit #(.LOCK_TRIES(A_TRIES), .BACKOFF_MAX(A_BMAX)) u_dut_a (
      .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy_o[0]),
      .req_op(req_op), .req_adr(req_adr), .req_dat(req_dat),
      .rsp_valid(rv_o[0]), .rsp_dat(rdat_o[0]), .rsp_err(err_o[0]),
      .mem_read(mr_o[0]), .mem_write(mw_o[0]), .mem_read_adr(mra_o[0]),
      .mem_write_adr(mwa_o[0]), .mem_write_dat(mwd_o[0]), .lock_adr(ladr_o[0]),
      .lock_en(le_o[0]), .unlock_en(ue_o[0]),
      .mem_dat(mem_dat), .mem_ac(mem_ac), .lock_ac(lock_ac)
   );

   mem_req_unit #(.LOCK_TRIES(B_TRIES), .BACKOFF_MAX(B_BMAX)) u_dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy_o[1]),
      .req_op(req_op), .req_adr(req_adr), .req_dat(req_dat),
      .rsp_valid(rv_o[1]), .rsp_dat(rdat_o[1]), .rsp_err(err_o[1]),
      .mem_read(mr_o[1]), .mem_write(mw_o[1]), .mem_read_adr(mra_o[1]),
      .mem_write_adr(mwa_o[1]), .mem_write_dat(mwd_o[1]), .lock_adr(ladr_o[1]),
      .lock_en(le_o[1]), .unlock_en(ue_o[1]),
      .mem_dat(mem_dat), .mem_ac(mem_ac), .lock_ac(lock_ac)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: expected per-cycle trace (cycle 0 = first cycle after the handshake).
   function automatic trace_t model(input logic [1:0] op, input logic [63:0] g,
                                    input logic [15:0] lv, input int tries, input int bmax);
      trace_t      e;
      logic [63:0] v;
      int          t;
      int          k;
      int          gap;
      e = '0;
      v = '0;
      t = 0;
      k = 0;
      if (op == 2'd2) begin
         while (t < 60) begin
            e.le[t] = 1'b1;
            if (g[t]) begin
               e.rsp_at = 7'(t + 1);
               break;
            end
            k++;
            if (k == tries) begin
               e.rsp_at = 7'(t + 1);
               e.err    = 1'b1;
               break;
            end
            gap = 1 << (k - 1);
            if (gap > bmax) gap = bmax;
            t = t + 1 + gap;
         end
      end else begin
         while (t < 60 && !g[t]) begin
            v[t] = 1'b1;
            t++;
         end
         v[t]     = 1'b1;
         e.rsp_at = 7'(t + 1);
         if (op == 2'd0) e.mr = v;
         if (op == 2'd1) e.mw = v;
         if (op == 2'd3) e.ue = v;
         e.dat = (op == 2'd0) ? lv : 16'h0;
      end
      return e;
   endfunction

   // Issue one request to instance s and record what it does until rsp_valid.
   task automatic drive_txn(input int s, input logic [1:0] op, input logic [15:0] adr,
                            input logic [15:0] dat, input logic [15:0] lv,
                            input logic [63:0] g, output trace_t o);
      int w;
      o        = '0;
      o.rsp_at = 7'h7F;
      @(posedge clk); #1;
      mem_ac    = 1'b0;
      lock_ac   = 1'b0;
      req_valid = 2'b00;
      req_valid[s] = 1'b1;
      req_op    = op;
      req_adr   = adr;
      req_dat   = dat;
      w = 0;
      @(negedge clk);
      while (rdy_o[s] !== 1'b1 && w < 20) begin
         @(posedge clk); #1;
         w++;
         @(negedge clk);
      end
      o.wt = 8'(w);
      @(posedge clk); #1;
      req_valid = 2'b00;
      req_op    = 2'($urandom);
      req_adr   = 16'($urandom);
      req_dat   = 16'($urandom);
      for (int i = 0; i < 64; i++) begin
         mem_ac  = (op < 2'd2)  ? g[i] : 1'($urandom);
         lock_ac = (op >= 2'd2) ? g[i] : 1'($urandom);
         mem_dat = g[i] ? lv : 16'($urandom);
         @(negedge clk);
         o.mr[i]  = mr_o[s];
         o.mw[i]  = mw_o[s];
         o.le[i]  = le_o[s];
         o.ue[i]  = ue_o[s];
         o.rdy[i] = rdy_o[s];
         if ((mr_o[s] | mw_o[s]) &&
             (mra_o[s] !== adr || mwa_o[s] !== adr || (op == 2'd1 && mwd_o[s] !== dat)))
            o.adr_bad = o.adr_bad + 8'd1;
         if ((le_o[s] | ue_o[s]) && ladr_o[s] !== adr[9:0])
            o.adr_bad = o.adr_bad + 8'd1;
         if (rv_o[s] === 1'b1) begin
            o.rsp_at = 7'(i);
            o.dat    = rdat_o[s];
            o.err    = err_o[s];
            break;
         end
         @(posedge clk); #1;
      end
      mem_ac  = 1'b0;
      lock_ac = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 2'b00; req_op = 2'd0; req_adr = '0; req_dat = '0;
      mem_dat = '0; mem_ac = 1'b0; lock_ac = 1'b0;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({rdy_o, rv_o, err_o, mr_o, mw_o, le_o, ue_o, rdat_o[0], rdat_o[1],
           mra_o[0], mwa_o[1], ladr_o[0]} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b rv=%b mr=%b mw=%b le=%b ue=%b want all 0",
                  rdy_o, rv_o, mr_o, mw_o, le_o, ue_o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rdy_o !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready_low: got %b want 00", rdy_o);
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({rdy_o, rv_o} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_ready_high: got rdy=%b rv=%b want rdy=11 rv=00", rdy_o, rv_o);
      end
   endtask

   task automatic test_load();
      trace_t o, e;
      e = model(2'd0, 64'h8, 16'hBEEF, A_TRIES, A_BMAX);
      drive_txn(0, 2'd0, 16'h0040, 16'h5555, 16'hBEEF, 64'h8, o);
      n_tests++;
      if ({o.mr, o.rsp_at, o.dat} !== {64'hF, 7'd4, 16'hBEEF}) begin
         n_fail++;
         $display("FAIL load_spec: got mr=%h at=%0d dat=%h want mr=f at=4 dat=beef", o.mr, o.rsp_at, o.dat);
      end
      n_tests++;
      if ({o.mr, o.mw, o.le, o.ue, o.rdy} !== {e.mr, e.mw, e.le, e.ue, e.rdy}) begin
         n_fail++;
         $display("FAIL load_lines: got %h want %h", {o.mr, o.mw, o.le, o.ue}, {e.mr, e.mw, e.le, e.ue});
      end
      n_tests++;
      if ({o.adr_bad, o.wt, o.err} !== {e.adr_bad, e.wt, e.err}) begin
         n_fail++;
         $display("FAIL load_adr: got bad=%0d wait=%0d err=%b want 0 0 0", o.adr_bad, o.wt, o.err);
      end
   endtask

   task automatic test_store();
      trace_t o, e;
      e = model(2'd1, 64'h1, 16'hAAAA, A_TRIES, A_BMAX);
      drive_txn(0, 2'd1, 16'h0010, 16'h1234, 16'hAAAA, 64'h1, o);
      n_tests++;
      if ({o.mw, o.rsp_at, o.dat} !== {64'h1, 7'd1, 16'h0}) begin
         n_fail++;
         $display("FAIL store_spec: got mw=%h at=%0d dat=%h want mw=1 at=1 dat=0", o.mw, o.rsp_at, o.dat);
      end
      n_tests++;
      if ({o.mr, o.mw, o.le, o.ue, o.rdy, o.adr_bad, o.wt} !==
          {e.mr, e.mw, e.le, e.ue, e.rdy, e.adr_bad, e.wt}) begin
         n_fail++;
         $display("FAIL store_lines: got %h bad=%0d want %h bad=0", {o.mr, o.mw}, o.adr_bad, {e.mr, e.mw});
      end
   endtask

   task automatic test_lock_backoff();
      trace_t      o, e;
      logic [63:0] g;
      g = {$urandom, $urandom};
      g[0] = 1'b0; g[2] = 1'b0; g[5] = 1'b0; g[10] = 1'b1;
      e = model(2'd2, g, 16'h0, A_TRIES, A_BMAX);
      drive_txn(0, 2'd2, 16'hFC05, 16'h0, 16'h0, g, o);
      n_tests++;
      if ({o.le, o.rsp_at, o.err} !== {64'h425, 7'd11, 1'b0}) begin
         n_fail++;
         $display("FAIL lock_gaps: got le=%h at=%0d err=%b want le=425 at=11 err=0", o.le, o.rsp_at, o.err);
      end
      n_tests++;
      if ({o.mr, o.mw, o.le, o.ue, o.rdy, o.adr_bad} !== {e.mr, e.mw, e.le, e.ue, e.rdy, e.adr_bad}) begin
         n_fail++;
         $display("FAIL lock_lines: got %h bad=%0d want %h", {o.le, o.ue}, o.adr_bad, {e.le, e.ue});
      end
   endtask

   task automatic test_lock_abort();
      trace_t o, e;
      drive_txn(0, 2'd2, 16'h0033, 16'h0, 16'h0, 64'h0, o);
      e = model(2'd2, 64'h0, 16'h0, A_TRIES, A_BMAX);
      n_tests++;
      if ({o.le, o.rsp_at, o.err} !== {64'h425, 7'd11, 1'b1}) begin
         n_fail++;
         $display("FAIL abort_a: got le=%h at=%0d err=%b want le=425 at=11 err=1", o.le, o.rsp_at, o.err);
      end
      n_tests++;
      if ({o.le, o.ue, o.mr, o.rdy} !== {e.le, e.ue, e.mr, e.rdy}) begin
         n_fail++;
         $display("FAIL abort_a_lines: got %h want %h", {o.le, o.ue}, {e.le, e.ue});
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({rdy_o[0], rv_o[0]} !== 2'b10) begin
         n_fail++;
         $display("FAIL abort_idle: got rdy=%b rv=%b want rdy=1 rv=0", rdy_o[0], rv_o[0]);
      end
      drive_txn(1, 2'd2, 16'h0123, 16'h0, 16'h0, 64'h0, o);
      e = model(2'd2, 64'h0, 16'h0, B_TRIES, B_BMAX);
      n_tests++;
      if ({o.le, o.rsp_at, o.err} !== {64'h2108425, 7'd26, 1'b1}) begin
         n_fail++;
         $display("FAIL abort_b_sat: got le=%h at=%0d err=%b want le=2108425 at=26 err=1", o.le, o.rsp_at, o.err);
      end
      n_tests++;
      if ({o.le, o.rsp_at, o.err, o.adr_bad} !== {e.le, e.rsp_at, e.err, e.adr_bad}) begin
         n_fail++;
         $display("FAIL abort_b_model: got le=%h at=%0d want le=%h at=%0d", o.le, o.rsp_at, e.le, e.rsp_at);
      end
   endtask

   task automatic test_back_to_back();
      trace_t o1, o2, e1, e2;
      drive_txn(0, 2'd2, 16'h0005, 16'h0, 16'h0, 64'h1, o1);
      drive_txn(0, 2'd3, 16'h0005, 16'h0, 16'h0, 64'h4, o2);
      e1 = model(2'd2, 64'h1, 16'h0, A_TRIES, A_BMAX);
      e2 = model(2'd3, 64'h4, 16'h0, A_TRIES, A_BMAX);
      n_tests++;
      if ({o1.le, o1.ue, o1.rsp_at, o1.err, o1.adr_bad} !== {e1.le, e1.ue, e1.rsp_at, e1.err, e1.adr_bad}) begin
         n_fail++;
         $display("FAIL b2b_lock: got le=%h ue=%h at=%0d bad=%0d want le=%h ue=0 at=%0d",
                  o1.le, o1.ue, o1.rsp_at, o1.adr_bad, e1.le, e1.rsp_at);
      end
      n_tests++;
      if ({o2.le, o2.ue, o2.rsp_at, o2.err, o2.adr_bad, o2.wt} !==
          {e2.le, e2.ue, e2.rsp_at, e2.err, e2.adr_bad, e2.wt}) begin
         n_fail++;
         $display("FAIL b2b_unlock: got ue=%h at=%0d wait=%0d bad=%0d want ue=%h at=%0d wait=0",
                  o2.ue, o2.rsp_at, o2.wt, o2.adr_bad, e2.ue, e2.rsp_at);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      req_valid = 2'b01; req_op = 2'd0; req_adr = 16'h0123; mem_ac = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rdy_o[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready: got %b want 1", rdy_o[0]);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1; mem_ac = 1'b1; mem_dat = 16'hDEAD;
      @(negedge clk);
      n_tests++;
      if (mr_o[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pending: got mem_read=%b want 1", mr_o[0]);
      end
      @(posedge clk); #1;
      reset = 1'b0; mem_ac = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({rdy_o[0], rv_o[0], err_o[0], mr_o[0], mw_o[0], le_o[0], ue_o[0],
           rdat_o[0], mra_o[0], mwa_o[0]} !== '0) begin
         n_fail++;
         $display("FAIL midrst_clear: got rdy=%b rv=%b mr=%b dat=%h adr=%h want all 0",
                  rdy_o[0], rv_o[0], mr_o[0], rdat_o[0], mra_o[0]);
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({rdy_o[0], rv_o[0]} !== 2'b10) begin
         n_fail++;
         $display("FAIL midrst_ready_after: got rdy=%b rv=%b want rdy=1 rv=0", rdy_o[0], rv_o[0]);
      end
   endtask

   task automatic test_random();
      trace_t      o, e;
      logic [63:0] g;
      logic [1:0]  op;
      logic [15:0] adr, dat, lv;
      int          s;
      for (int n = 0; n < 30; n++) begin
         s   = int'($urandom_range(0, 1));
         op  = 2'($urandom);
         adr = 16'($urandom);
         dat = 16'($urandom);
         lv  = 16'($urandom);
         g   = {$urandom, $urandom} & {$urandom, $urandom};
         if (op != 2'd2) g[$urandom_range(0, 12)] = 1'b1;
         drive_txn(s, op, adr, dat, lv, g, o);
         e = (s == 0) ? model(op, g, lv, A_TRIES, A_BMAX) : model(op, g, lv, B_TRIES, B_BMAX);
         n_tests++;
         if ({o.mr, o.mw, o.le, o.ue, o.rdy} !== {e.mr, e.mw, e.le, e.ue, e.rdy}) begin
            n_fail++;
            $display("FAIL rand_lines[%0d] dut=%0d op=%0d: got %h want %h", n, s, op,
                     {o.mr, o.mw, o.le, o.ue}, {e.mr, e.mw, e.le, e.ue});
         end
         n_tests++;
         if ({o.rsp_at, o.dat, o.err, o.adr_bad, o.wt} !== {e.rsp_at, e.dat, e.err, e.adr_bad, e.wt}) begin
            n_fail++;
            $display("FAIL rand_rsp[%0d] dut=%0d op=%0d: got at=%0d dat=%h err=%b bad=%0d wait=%0d want at=%0d dat=%h err=%b",
                     n, s, op, o.rsp_at, o.dat, o.err, o.adr_bad, o.wt, e.rsp_at, e.dat, e.err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_lock_backoff();
      test_lock_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_req_unit.md
MEM_REQ_UNIT -- requirements
Module: mem_req_unit

Interface
REQ-001 Parameter LOCK_TRIES, 16, failed lock attempts before the unit SHALL abort with an error.
REQ-002 Parameter BACKOFF_MAX, 8, upper bound (cycles) the backoff interval SHALL saturate at.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  core request present.
REQ-006 req_ready  out  1  unit accepts a request this cycle.
REQ-007 req_op  in  2  operation code: LOAD=0, STORE=1, LOCK=2, UNLOCK=3.
REQ-008 req_adr  in  16  word address; bits [9:0] give the mutex index for LOCK/UNLOCK.
REQ-009 req_dat  in  16  store data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_dat  out  16  load data; zero for other ops.
REQ-012 rsp_err  out  1  lock aborted after LOCK_TRIES failures.
REQ-013 mem_read, mem_write  out  1 each  shared-memory request lines to the arbiter.
REQ-014 mem_read_adr, mem_write_adr  out  16 each  both SHALL carry the latched address for LOAD and STORE.
REQ-015 mem_write_dat  out  16  latched store data.
REQ-016 lock_adr  out  10  latched mutex index; lock_en, unlock_en  out  1 each.
REQ-017 mem_dat  in  16, mem_ac  in  1, lock_ac  in  1  arbiter data and same-cycle grants.

Function
REQ-018 The FSM SHALL have states IDLE, MEM, LOCK, BACKOFF, UNLOCK, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake (req_valid & req_ready) SHALL latch op, adr, dat and move to MEM (LOAD/STORE), LOCK, or UNLOCK.
REQ-020 MEM SHALL hold mem_read (LOAD) or mem_write (STORE) high with stable address/data every cycle until mem_ac=1, then go to RESP.
REQ-021 On a LOAD grant cycle, mem_dat SHALL be captured into rsp_dat at that posedge.
REQ-022 LOCK SHALL assert lock_en; lock_ac=1 SHALL go to RESP with rsp_err=0; lock_ac=0 SHALL increment the try counter and go to BACKOFF.
REQ-023 BACKOFF SHALL deassert all arbiter lines for the current interval; the interval SHALL start at 1 and double after each failure, saturating at BACKOFF_MAX; on expiry the FSM SHALL return to LOCK.
REQ-024 When the try counter reaches LOCK_TRIES, the FSM SHALL go to RESP with rsp_err=1 instead of entering BACKOFF.
REQ-025 UNLOCK SHALL hold unlock_en until lock_ac=1, then go to RESP; UNLOCK SHALL never error.
REQ-026 RESP SHALL assert rsp_valid for exactly one cycle and return to IDLE; no response backpressure exists.
REQ-027 Minimum latency SHALL be: handshake in cycle N, grant in N+1, rsp_valid in N+2.
REQ-028 At most one of mem_read, mem_write, lock_en, unlock_en SHALL be high in any cycle.
REQ-029 Try counter and backoff interval SHALL clear on every accepted request.
REQ-030 Grants arriving in states that do not request them SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE, clear counters, latches, rsp_dat, rsp_err, rsp_valid, and all arbiter request lines to 0 on the next posedge, including mid-operation; no partial response SHALL be issued.
REQ-032 req_ready SHALL be 0 during the reset cycle and 1 in the first cycle after.

Structure
REQ-033 A shared package mem_req_pkg SHALL hold the op enum, state enum and the mutex index width (10).
REQ-034 The backoff interval/expiry counter SHALL be a sub-module lock_backoff (inputs: clear, fail, tick; output: expired).

Verification
REQ-035 LOAD adr=0x0040, mem_ac held 0 for 3 cycles then 1 with mem_dat=0xBEEF -> mem_read high 4 cycles, rsp_valid next cycle, rsp_dat=0xBEEF.
REQ-036 STORE adr=0x0010, dat=0x1234, immediate grant -> mem_write=1 with both addresses 0x0010 for one cycle, rsp_valid at N+2, rsp_dat=0.
REQ-037 LOCK idx=5, lock_ac=0 on first three attempts -> lock_en gaps of 1, 2, 4 cycles, success on fourth attempt, rsp_err=0.
REQ-038 LOCK with lock_ac always 0, LOCK_TRIES=4 -> four lock_en attempts, rsp_valid with rsp_err=1, back in IDLE.
REQ-039 Reset asserted while in MEM awaiting grant -> next cycle all outputs 0, no rsp_valid, then req_ready=1.
REQ-040 Back-to-back LOCK then UNLOCK idx=5 -> unlock_en asserted only after the lock response, lock_adr=5 on both.
